// File: rtl/lsu_stage_pkg.sv
// Shared definitions for the load/store stage: opcode patterns, the
// instruction record, FSM states and byte-lane helper functions.
package lsu_stage_pkg;

    // Executed-instruction opcodes; memory ops live in the upper half.
    typedef enum logic [3:0] {
        kADDU = 4'h0,
        kSUBU = 4'h1,
        kAND  = 4'h2,
        kOR   = 4'h3,
        kXOR  = 4'h4,
        kSLT  = 4'h5,
        kLW   = 4'h8,
        kLBU  = 4'h9,
        kSW   = 4'hA,
        kSB   = 4'hB
    } opcode_e;

    typedef struct packed {
        opcode_e opcode;
    } instruction_s;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_e;

    function automatic logic is_load(input opcode_e op);
        return (op == kLW) || (op == kLBU);
    endfunction

    function automatic logic is_store(input opcode_e op);
        return (op == kSW) || (op == kSB);
    endfunction

    // Word ops touch all four lanes; byte ops touch the addressed lane only.
    function automatic logic [3:0] byte_enable(input logic is_byte, input logic [1:0] off);
        return is_byte ? (4'b0001 << off) : 4'hF;
    endfunction

    // Byte stores replicate the low byte so it lands on whichever lane is enabled.
    function automatic logic [31:0] store_lanes(input logic is_byte, input logic [31:0] data);
        return is_byte ? {4{data[7:0]}} : data;
    endfunction

    // Byte loads zero-extend the addressed lane of the returned word.
    function automatic logic [31:0] lane_extract(input logic is_byte, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [7:0] lane;
        case (off)
            2'd0:    lane = rdata[7:0];
            2'd1:    lane = rdata[15:8];
            2'd2:    lane = rdata[23:16];
            default: lane = rdata[31:24];
        endcase
        return is_byte ? {24'b0, lane} : rdata;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane steering: store byte enables / write data and
// load-data lane extraction.
module lsu_byte_lane
    import lsu_stage_pkg::*;
(
    input  logic        st_is_byte,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    input  logic        ld_is_byte,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    output logic [31:0] ld_data
);

    // Steer store data onto lanes and pick the load lane.
    always_comb begin
        st_be    = byte_enable(st_is_byte, st_off);
        st_wdata = store_lanes(st_is_byte, st_data);
        ld_data  = lane_extract(ld_is_byte, ld_off, ld_rdata);
    end

endmodule

// File: rtl/lsu_stage.sv
// Load/store + writeback stage. ALU results go straight to writeback; load
// and store opcodes run one data-memory access through req/gnt/rvalid, with
// misalignment detection and an access timeout.
module lsu_stage
    import lsu_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_i,
    output logic         ready_o,
    input  instruction_s op_i,
    input  logic [31:0]  result_i,
    input  logic [31:0]  addr_i,
    input  logic [4:0]   wb_sel_i,
    input  logic         wb_en_i,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_addr_o,
    output logic [31:0]  mem_wdata_o,
    output logic [3:0]   mem_be_o,
    input  logic         mem_gnt_i,
    input  logic         mem_rvalid_i,
    input  logic [31:0]  mem_rdata_i,
    output logic         wb_valid_o,
    output logic [4:0]   wb_sel_o,
    output logic [31:0]  wb_data_o,
    output logic         misalign_o,
    output logic         timeout_o
);

    lsu_state_e  state_q, state_d;
    logic        ready_q, ready_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_sel_q, wb_sel_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        misalign_q, misalign_d;
    logic        timeout_q, timeout_d;
    logic        ld_byte_q, ld_byte_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    opcode_e     op;
    logic        accept;
    logic        acc_load;
    logic        acc_store;
    logic        acc_mem;
    logic [31:0] acc_addr;
    logic        acc_misalign;
    logic [16:0] tmo_next;
    logic        tmo_expire;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    assign op        = op_i.opcode;
    assign accept    = valid_i && ready_q && (state_q == IDLE);
    assign acc_load  = is_load(op);
    assign acc_store = is_store(op);
    assign acc_mem   = acc_load || acc_store;
    // Loads take their address from the ALU result, stores from the rs operand.
    assign acc_addr  = acc_store ? addr_i : result_i;
    assign acc_misalign = ((op == kLW) || (op == kSW)) && (acc_addr[1:0] != 2'b00);

    // Timeout fires on the cycle whose increment would reach the limit.
    assign tmo_next   = {1'b0, tmo_cnt_q} + 17'd1;
    assign tmo_expire = (tmo_next == 17'(TIMEOUT_CYCLES));

    lsu_byte_lane u_byte_lane (
        .st_is_byte (op == kSB),
        .st_off     (acc_addr[1:0]),
        .st_data    (result_i),
        .ld_is_byte (ld_byte_q),
        .ld_off     (ld_off_q),
        .ld_rdata   (mem_rdata_i),
        .st_be      (st_be),
        .st_wdata   (st_wdata),
        .ld_data    (ld_data)
    );

    // State and output registers; reset aborts any access immediately.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: every register, datapath included, is reset because all of them drive ports.
        if (reset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_sel_q    <= '0;
            wb_data_q   <= '0;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
            ld_byte_q   <= 1'b0;
            ld_off_q    <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q     <= state_d;
            ready_q     <= ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            wb_valid_q  <= wb_valid_d;
            wb_sel_q    <= wb_sel_d;
            wb_data_q   <= wb_data_d;
            misalign_q  <= misalign_d;
            timeout_q   <= timeout_d;
            ld_byte_q   <= ld_byte_d;
            ld_off_q    <= ld_off_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    // Next-state logic: IDLE -> REQ on an aligned memory op, REQ -> WAIT on a load grant.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && acc_mem && !acc_misalign) state_d = REQ;
            REQ: begin
                if (mem_gnt_i)       state_d = mem_we_q ? IDLE : WAIT;
                else if (tmo_expire) state_d = IDLE;
            end
            WAIT: if (mem_rvalid_i || tmo_expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values; pulses default low, everything else holds.
    always_comb begin
        // NOTE: defaults first so no path through the case can infer a latch.
        ready_d     = ready_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        wb_valid_d  = 1'b0;
        wb_sel_d    = wb_sel_q;
        wb_data_d   = wb_data_q;
        misalign_d  = 1'b0;
        timeout_d   = 1'b0;
        ld_byte_d   = ld_byte_q;
        ld_off_d    = ld_off_q;
        tmo_cnt_d   = tmo_cnt_q;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    wb_sel_d = wb_sel_i;
                    if (!acc_mem) begin
                        wb_data_d  = result_i;
                        wb_valid_d = wb_en_i;
                    end else if (acc_misalign) begin
                        misalign_d = 1'b1;
                    end else begin
                        ready_d     = 1'b0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = acc_store;
                        mem_addr_d  = {acc_addr[31:2], 2'b00};
                        mem_be_d    = acc_store ? st_be : 4'hF;
                        mem_wdata_d = acc_store ? st_wdata : mem_wdata_q;
                        ld_byte_d   = (op == kLBU);
                        ld_off_d    = acc_addr[1:0];
                        tmo_cnt_d   = '0;
                    end
                end
            end
            REQ: begin
                tmo_cnt_d = tmo_next[15:0];
                if (mem_gnt_i) begin
                    mem_req_d = 1'b0;
                    ready_d   = mem_we_q;
                end else if (tmo_expire) begin
                    mem_req_d = 1'b0;
                    timeout_d = 1'b1;
                    ready_d   = 1'b1;
                end
            end
            WAIT: begin
                tmo_cnt_d = tmo_next[15:0];
                if (mem_rvalid_i) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = ld_data;
                    ready_d    = 1'b1;
                end else if (tmo_expire) begin
                    timeout_d = 1'b1;
                    ready_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ready_o     = ready_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;
    assign wb_valid_o  = wb_valid_q;
    assign wb_sel_o    = wb_sel_q;
    assign wb_data_o   = wb_data_q;
    assign misalign_o  = misalign_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: writebacks are predicted into a scoreboard
// queue when stimulus is driven and popped when the DUT strobes wb_valid_o.
// A second instance with a short timeout covers the abort path.
module tb_lsu_stage;
    import lsu_stage_pkg::*;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] data;
    } wb_exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_i, valid_t;
    instruction_s op_i;
    logic [31:0]  result_i, addr_i;
    logic [4:0]   wb_sel_i;
    logic         wb_en_i;
    logic         mem_gnt_i, mem_rvalid_i, rvalid_t;
    logic [31:0]  mem_rdata_i;

    logic         ready_o, mem_req_o, mem_we_o, wb_valid_o, misalign_o, timeout_o;
    logic [31:0]  mem_addr_o, mem_wdata_o, wb_data_o;
    logic [3:0]   mem_be_o;
    logic [4:0]   wb_sel_o;

    logic         ready_t, mem_req_t, mem_we_t, wb_valid_t, misalign_t, timeout_t;
    logic [31:0]  mem_addr_t, mem_wdata_t, wb_data_t;
    logic [3:0]   mem_be_t;
    logic [4:0]   wb_sel_t;

    int checks = 0;
    int errors = 0;
    wb_exp_t exp_q[$];
    wb_exp_t mon_e;

    always #5 clk = ~clk;

    lsu_stage dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
        .result_i(result_i), .addr_i(addr_i), .wb_sel_i(wb_sel_i), .wb_en_i(wb_en_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .wb_valid_o(wb_valid_o),
        .wb_sel_o(wb_sel_o), .wb_data_o(wb_data_o), .misalign_o(misalign_o),
        .timeout_o(timeout_o)
    );

    lsu_stage #(.TIMEOUT_CYCLES(4)) dut_t (
        .clk(clk), .reset(reset), .valid_i(valid_t), .ready_o(ready_t), .op_i(op_i),
        .result_i(result_i), .addr_i(addr_i), .wb_sel_i(wb_sel_i), .wb_en_i(wb_en_i),
        .mem_req_o(mem_req_t), .mem_we_o(mem_we_t), .mem_addr_o(mem_addr_t),
        .mem_wdata_o(mem_wdata_t), .mem_be_o(mem_be_t), .mem_gnt_i(1'b0),
        .mem_rvalid_i(rvalid_t), .mem_rdata_i(mem_rdata_i), .wb_valid_o(wb_valid_t),
        .wb_sel_o(wb_sel_t), .wb_data_o(wb_data_t), .misalign_o(misalign_t),
        .timeout_o(timeout_t)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input opcode_e op, input logic [31:0] res, input logic [31:0] addr,
                         input logic [4:0] sel, input logic en);
        valid_i   = 1'b1;
        op_i.opcode = op;
        result_i  = res;
        addr_i    = addr;
        wb_sel_i  = sel;
        wb_en_i   = en;
    endtask

    // Scoreboard: every writeback strobe must match the oldest prediction.
    always @(negedge clk) begin
        if (!reset && wb_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", {31'b0, wb_valid_o}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_sel", {27'b0, wb_sel_o}, {27'b0, mon_e.sel});
                chk("wb_data", wb_data_o, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        valid_i = 1'b0; valid_t = 1'b0; op_i = '0; result_i = '0; addr_i = '0;
        wb_sel_i = '0; wb_en_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        rvalid_t = 1'b0; mem_rdata_i = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, ready_o}, 32'd0);
        chk("rst_req", {31'b0, mem_req_o}, 32'd0);
        chk("rst_we", {31'b0, mem_we_o}, 32'd0);
        chk("rst_wb_valid", {31'b0, wb_valid_o}, 32'd0);
        chk("rst_misalign", {31'b0, misalign_o}, 32'd0);
        chk("rst_timeout", {31'b0, timeout_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_be", {28'b0, mem_be_o}, 32'd0);
        chk("rst_wb_data", wb_data_o, 32'd0);
        chk("rst_wb_sel", {27'b0, wb_sel_o}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'b0, ready_o}, 32'd1);

        // Three back-to-back ALU ops, then one with wb_en_i low.
        drive(kADDU, 32'h0000_0005, 32'h0, 5'd3, 1'b1);
        exp_q.push_back('{5'd3, 32'h0000_0005});
        @(negedge clk);
        chk("alu_strobe1", {31'b0, wb_valid_o}, 32'd1);
        drive(kSUBU, 32'h0000_0011, 32'h0, 5'd4, 1'b1);
        exp_q.push_back('{5'd4, 32'h0000_0011});
        @(negedge clk);
        chk("alu_strobe2", {31'b0, wb_valid_o}, 32'd1);
        drive(kXOR, 32'hFFFF_FFFF, 32'h0, 5'd31, 1'b1);
        exp_q.push_back('{5'd31, 32'hFFFF_FFFF});
        @(negedge clk);
        chk("alu_strobe3", {31'b0, wb_valid_o}, 32'd1);
        drive(kOR, 32'h0000_0055, 32'h0, 5'd6, 1'b0);
        @(negedge clk);
        valid_i = 1'b0;
        chk("alu_no_wb_en", {31'b0, wb_valid_o}, 32'd0);
        chk("alu_ready", {31'b0, ready_o}, 32'd1);

        // kLW 0x100, grant two cycles late, rvalid three cycles after grant.
        drive(kLW, 32'h0000_0100, 32'hFFFF_FFF0, 5'd7, 1'b1);
        exp_q.push_back('{5'd7, 32'hDEAD_BEEF});
        @(negedge clk);
        valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("lw_req", {31'b0, mem_req_o}, 32'd1);
            chk("lw_addr", mem_addr_o, 32'h0000_0100);
            chk("lw_be", {28'b0, mem_be_o}, 32'hF);
            chk("lw_we", {31'b0, mem_we_o}, 32'd0);
            chk("lw_ready_req", {31'b0, ready_o}, 32'd0);
            if (i == 2) mem_gnt_i = 1'b1;
            @(negedge clk);
        end
        mem_gnt_i = 1'b0;
        chk("lw_req_drop", {31'b0, mem_req_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("lw_ready_wait", {31'b0, ready_o}, 32'd0);
            chk("lw_no_early_wb", {31'b0, wb_valid_o}, 32'd0);
            if (i == 2) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = 32'hDEAD_BEEF;
            end
            @(negedge clk);
        end
        mem_rvalid_i = 1'b0;
        chk("lw_wb_strobe", {31'b0, wb_valid_o}, 32'd1);
        chk("lw_ready_back", {31'b0, ready_o}, 32'd1);

        // kLBU 0x102: lane 2 of the returned word, zero-extended.
        drive(kLBU, 32'h0000_0102, 32'h0, 5'd9, 1'b1);
        exp_q.push_back('{5'd9, 32'h0000_00BB});
        @(negedge clk);
        valid_i = 1'b0;
        chk("lbu_addr", mem_addr_o, 32'h0000_0100);
        chk("lbu_be", {28'b0, mem_be_o}, 32'hF);
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hAABB_CCDD;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        chk("lbu_wb_strobe", {31'b0, wb_valid_o}, 32'd1);

        // kSB 0x203: top lane enabled, byte replicated, no writeback.
        drive(kSB, 32'h1234_5677, 32'h0000_0203, 5'd2, 1'b1);
        @(negedge clk);
        valid_i = 1'b0;
        chk("sb_req", {31'b0, mem_req_o}, 32'd1);
        chk("sb_we", {31'b0, mem_we_o}, 32'd1);
        chk("sb_addr", mem_addr_o, 32'h0000_0200);
        chk("sb_be", {28'b0, mem_be_o}, 32'h8);
        chk("sb_wdata", mem_wdata_o, 32'h7777_7777);
        chk("sb_ready_req", {31'b0, ready_o}, 32'd0);
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        chk("sb_req_drop", {31'b0, mem_req_o}, 32'd0);
        chk("sb_ready_after_gnt", {31'b0, ready_o}, 32'd1);
        chk("sb_no_wb", {31'b0, wb_valid_o}, 32'd0);

        // kSW aligned 0x204, grant one cycle late.
        drive(kSW, 32'hCAFE_F00D, 32'h0000_0204, 5'd1, 1'b1);
        @(negedge clk);
        valid_i = 1'b0;
        chk("sw_addr", mem_addr_o, 32'h0000_0204);
        chk("sw_be", {28'b0, mem_be_o}, 32'hF);
        chk("sw_wdata", mem_wdata_o, 32'hCAFE_F00D);
        @(negedge clk);
        chk("sw_req_held", {31'b0, mem_req_o}, 32'd1);
        chk("sw_wdata_held", mem_wdata_o, 32'hCAFE_F00D);
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        chk("sw_ready_after_gnt", {31'b0, ready_o}, 32'd1);
        chk("sw_no_wb", {31'b0, wb_valid_o}, 32'd0);

        // Misaligned kSW 0x002 and kLW 0x101.
        drive(kSW, 32'h0000_0BAD, 32'h0000_0002, 5'd1, 1'b1);
        @(negedge clk);
        drive(kLW, 32'h0000_0101, 32'h0, 5'd5, 1'b1);
        chk("msw_pulse", {31'b0, misalign_o}, 32'd1);
        chk("msw_no_req", {31'b0, mem_req_o}, 32'd0);
        chk("msw_ready", {31'b0, ready_o}, 32'd1);
        @(negedge clk);
        valid_i = 1'b0;
        chk("mlw_pulse", {31'b0, misalign_o}, 32'd1);
        chk("mlw_no_req", {31'b0, mem_req_o}, 32'd0);
        @(negedge clk);
        chk("mis_pulse_end", {31'b0, misalign_o}, 32'd0);
        chk("mis_no_req", {31'b0, mem_req_o}, 32'd0);
        chk("mis_no_wb", {31'b0, wb_valid_o}, 32'd0);

        // Timeout on the TIMEOUT_CYCLES=4 instance: kLW never granted.
        op_i.opcode = kLW;
        result_i = 32'h0000_0040;
        valid_t = 1'b1;
        @(negedge clk);
        valid_t = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_req_high", {31'b0, mem_req_t}, 32'd1);
            chk("to_no_pulse_yet", {31'b0, timeout_t}, 32'd0);
            @(negedge clk);
        end
        chk("to_req_drop", {31'b0, mem_req_t}, 32'd0);
        chk("to_pulse", {31'b0, timeout_t}, 32'd1);
        chk("to_ready", {31'b0, ready_t}, 32'd1);
        chk("to_no_wb", {31'b0, wb_valid_t}, 32'd0);
        @(negedge clk);
        chk("to_pulse_end", {31'b0, timeout_t}, 32'd0);
        rvalid_t = 1'b1;
        mem_rvalid_i = 1'b1;
        @(negedge clk);
        rvalid_t = 1'b0;
        mem_rvalid_i = 1'b0;
        chk("to_stray_rvalid", {31'b0, wb_valid_t}, 32'd0);
        chk("idle_stray_rvalid", {31'b0, wb_valid_o}, 32'd0);

        // Reset asserted mid-WAIT: everything drops at once, no writeback.
        drive(kLW, 32'h0000_0300, 32'h0, 5'd12, 1'b1);
        @(negedge clk);
        valid_i = 1'b0;
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        chk("rw_in_wait", {31'b0, ready_o}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rw_ready", {31'b0, ready_o}, 32'd0);
        chk("rw_req", {31'b0, mem_req_o}, 32'd0);
        chk("rw_addr", mem_addr_o, 32'd0);
        chk("rw_be", {28'b0, mem_be_o}, 32'd0);
        chk("rw_wb_sel", {27'b0, wb_sel_o}, 32'd0);
        chk("rw_wb_data", wb_data_o, 32'd0);
        chk("rw_wdata", mem_wdata_o, 32'd0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h5555_AAAA;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        chk("rw_no_wb", {31'b0, wb_valid_o}, 32'd0);
        @(negedge clk);
        chk("sb_drain", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
